mem_arbiter: RTL

Shares the single-port memory between three requesters: instruction fetch (driven during the fetch state), data load/store (driven during the load and store states), and an external DMA/port requester. It arbitrates round-robin and holds the selected request stable on the memory bus for a fixed number of wait cycles. It returns read data with a one-cycle ack pulse. It sits between the control sequencer, the register datapath and the memory.

---
 rtl/mem_arbiter.sv | 133 +++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between instruction fetch,
// data load/store and an external DMA requester. The winning request is latched
// and held on the memory bus for WAIT_CYCLES+1 cycles. The block then returns a
// one-cycle ack to the granted requester, together with the read data.
module mem_arbiter #(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 8,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [2:0]              req,
  input  logic [2:0]              we,
  input  logic [3*ADDR_WIDTH-1:0] addr,
  input  logic [3*DATA_WIDTH-1:0] wdata,
  output logic [2:0]              ack,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic                    busy,
  output logic [1:0]              gnt_id,
  output logic                    mem_en,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  input  logic [DATA_WIDTH-1:0]   mem_rdata
);

  localparam int NUM_REQ = 3;
  localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  typedef struct packed {
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
  } mreq_t;

  state_t     state, state_nxt;
  logic [3:0] cnt;
  logic [1:0] last;
  logic [1:0] win;
  logic [1:0] idx;
  logic       found;
  logic       last_cyc;
  mreq_t      lanes [NUM_REQ];

  // Unpack each requester's slice of the flat request buses.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    assign lanes[i] = '{we:    we[i],
                        addr:  addr[i*ADDR_WIDTH +: ADDR_WIDTH],
                        wdata: wdata[i*DATA_WIDTH +: DATA_WIDTH]};
  end

  assign last_cyc = (cnt == WAIT_LAST);

  // Round-robin pick: first requesting index searching circularly from last+1.
  always_comb begin
    win   = last;
    found = 1'b0;
    idx   = 2'd0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = 2'((int'(last) + k) % NUM_REQ);
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic: grant from IDLE, hold for WAIT_CYCLES+1, one DONE cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|req)    state_nxt = ACCESS;
      ACCESS:  if (last_cyc) state_nxt = DONE;
      DONE:                  state_nxt = IDLE;
      default:               state_nxt = IDLE;
    endcase
  end

  // Memory bus, ack/rdata and arbitration pointer; reset aborts any transaction.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ack       <= '0;
      rdata     <= '0;
      busy      <= 1'b0;
      gnt_id    <= 2'd0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cnt       <= 4'd0;
      last      <= 2'd2;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            mem_en    <= 1'b1;
            mem_we    <= lanes[win].we;
            mem_addr  <= lanes[win].addr;
            mem_wdata <= lanes[win].wdata;
            busy      <= 1'b1;
            gnt_id    <= win;
            last      <= win;
            cnt       <= 4'd0;
          end
        end
        ACCESS: begin
          if (last_cyc) begin
            if (!mem_we) rdata <= mem_rdata;
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            ack    <= 3'b001 << gnt_id;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        DONE: begin
          ack  <= '0;
          busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
